// File: rtl/output_hold_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_hold_driver_pkg: state encoding and width helper               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package output_hold_driver_pkg;

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_HOLD = 1'b1;

   // Bits needed to hold the value n-1, never less than one.
   function automatic int ohd_clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/output_hold_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_hold_driver_if: producer handshake and held output bundle      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface output_hold_driver_if #(
   parameter int DATA_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic                  din_ready;
   logic [DATA_WIDTH-1:0] dout;
   logic                  busy;

   modport master (output din, output din_valid, input din_ready, input dout, input busy);
   modport slave  (input din, input din_valid, output din_ready, output dout, output busy);
endinterface
`default_nettype wire

// File: rtl/output_hold_driver_hold_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hold_timer: hold-window counter with restart and terminal count       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hold_timer #(
   parameter int PERIOD = 256,
   parameter int CNT_W  = 8
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_run,
   input  logic i_start,
   output logic o_terminal
);
   localparam logic [CNT_W-1:0] c_TERM = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   // Parked at zero outside a window so the first hold cycle starts from 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (!i_run || i_start || o_terminal) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   assign o_terminal = i_run && (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/output_hold_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_hold_driver: output vector with minimum hold time per change   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module output_hold_driver
   import output_hold_driver_pkg::*;
#(
   parameter int DATA_WIDTH        = 1,
   parameter int HOLD_PERIOD       = 256,
   parameter int HOLD_PERIOD_CLOG2 = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   output_hold_driver_if.slave   bus
);

   if (HOLD_PERIOD < 1 || HOLD_PERIOD_CLOG2 < ohd_clog2(HOLD_PERIOD)) begin : g_param_check
      $error("output_hold_driver: HOLD_PERIOD must be >= 1 and HOLD_PERIOD-1 must fit in HOLD_PERIOD_CLOG2 bits");
   end

   logic [0:0]            r_state;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [DATA_WIDTH-1:0] r_pend;
   logic                  r_pend_valid;

   logic                  w_ready;
   logic                  w_xfer;
   logic                  w_tc;
   logic                  w_has_next;
   logic [DATA_WIDTH-1:0] w_next;
   logic                  w_load;
   logic                  w_hold;

   assign w_hold  = (r_state == c_ST_HOLD);
   assign w_ready = resetn & (~w_hold | ~r_pend_valid);
   assign w_xfer  = bus.din_valid & w_ready;

   // Pending value wins at terminal count; otherwise a same-edge transfer bypasses.
   always_comb begin
      w_has_next = 1'b0;
      w_next     = r_pend;
      if (r_pend_valid) begin
         w_has_next = 1'b1;
      end else if (w_xfer) begin
         w_has_next = 1'b1;
         w_next     = bus.din;
      end
   end

   assign w_load = w_hold ? (w_tc && w_has_next && (w_next != r_dout))
                          : (w_xfer && (bus.din != r_dout));

   hold_timer #(
      .PERIOD (HOLD_PERIOD),
      .CNT_W  (HOLD_PERIOD_CLOG2)
   ) u_hold_timer (
      .clk        (clk),
      .resetn     (resetn),
      .i_run      (w_hold),
      .i_start    (w_load),
      .o_terminal (w_tc)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= c_ST_IDLE;
         r_dout       <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_load) begin
                  r_dout  <= bus.din;
                  r_state <= c_ST_HOLD;
               end
            end
            c_ST_HOLD: begin
               if (w_tc) begin
                  r_pend_valid <= 1'b0;
                  if (w_load) begin
                     r_dout <= w_next;
                  end else begin
                     r_state <= c_ST_IDLE;
                  end
               end else if (w_xfer) begin
                  r_pend       <= bus.din;
                  r_pend_valid <= 1'b1;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign bus.din_ready = w_ready;
   assign bus.dout      = r_dout;
   assign bus.busy      = w_hold;

endmodule
`default_nettype wire

// File: tb/tb_output_hold_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_output_hold_driver: two instances (hold 4 and hold 1) vs. model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_output_hold_driver;
   localparam int W    = 4;
   localparam int NDUT = 2;

   logic         clk       = 1'b0;
   logic         resetn    = 1'b0;
   logic [W-1:0] din       = '0;
   logic         din_valid = 1'b0;

   int n_pass  = 0;
   int n_total = 0;
   int edge_n  = 0;

   int           per      [NDUT] = '{4, 1};
   logic [W-1:0] m_dout   [NDUT];
   logic [W-1:0] m_pend   [NDUT];
   logic [W-1:0] prev_act [NDUT];
   bit           m_pv     [NDUT];
   bit           m_busy   [NDUT];
   bit           chg_seen [NDUT];
   int           m_el     [NDUT];
   int           last_chg [NDUT];
   logic [W-1:0] chg_q [$];

   logic [W-1:0] act_dout [NDUT];
   logic         act_rdy  [NDUT];
   logic         act_busy [NDUT];

   always #5 clk = ~clk;

   output_hold_driver_if #(.DATA_WIDTH(W)) bus4 ();
   output_hold_driver_if #(.DATA_WIDTH(W)) bus1 ();

   assign bus4.din       = din;
   assign bus4.din_valid = din_valid;
   assign bus1.din       = din;
   assign bus1.din_valid = din_valid;

   output_hold_driver #(.DATA_WIDTH(W), .HOLD_PERIOD(4), .HOLD_PERIOD_CLOG2(2)) u_dut4 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus4)
   );

   output_hold_driver #(.DATA_WIDTH(W), .HOLD_PERIOD(1), .HOLD_PERIOD_CLOG2(1)) u_dut1 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus1)
   );

   always_comb begin
      act_dout[0] = bus4.dout;
      act_rdy[0]  = bus4.din_ready;
      act_busy[0] = bus4.busy;
      act_dout[1] = bus1.dout;
      act_rdy[1]  = bus1.din_ready;
      act_busy[1] = bus1.busy;
   end

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_dout[k]   = '0;
         m_pend[k]   = '0;
         m_pv[k]     = 1'b0;
         m_busy[k]   = 1'b0;
         m_el[k]     = 0;
         prev_act[k] = '0;
         chg_seen[k] = 1'b0;
      end
   endtask

   // One clock: drive at negedge, check ready/busy, clock, advance model, check dout and spacing.
   task automatic step(input bit v, input logic [W-1:0] d);
      bit           exp_rdy [NDUT];
      bit           x;
      bit           have;
      logic [W-1:0] nv;
      din_valid = v;
      din       = d;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         exp_rdy[k] = resetn && (!m_busy[k] || !m_pv[k]);
         n_total++;
         if (act_rdy[k] !== exp_rdy[k])
            $display("FAIL din_ready dut%0d t=%0t got %b expected %b", k, $time, act_rdy[k], exp_rdy[k]);
         else n_pass++;
         n_total++;
         if (act_busy[k] !== m_busy[k])
            $display("FAIL busy dut%0d t=%0t got %b expected %b", k, $time, act_busy[k], m_busy[k]);
         else n_pass++;
      end
      @(posedge clk);
      edge_n++;
      for (int k = 0; k < NDUT; k++) begin
         x = v && exp_rdy[k];
         if (!m_busy[k]) begin
            if (x && d != m_dout[k]) begin
               m_dout[k] = d;
               m_busy[k] = 1'b1;
               m_el[k]   = 0;
            end
         end else if (m_el[k] == per[k] - 1) begin
            have = 1'b0;
            nv   = '0;
            if (m_pv[k]) begin
               nv      = m_pend[k];
               have    = 1'b1;
               m_pv[k] = 1'b0;
            end else if (x) begin
               nv   = d;
               have = 1'b1;
            end
            m_el[k] = 0;
            if (have && nv != m_dout[k]) m_dout[k] = nv;
            else m_busy[k] = 1'b0;
         end else begin
            if (x) begin
               m_pend[k] = d;
               m_pv[k]   = 1'b1;
            end
            m_el[k]++;
         end
      end
      #1;
      for (int k = 0; k < NDUT; k++) begin
         n_total++;
         if (act_dout[k] !== m_dout[k])
            $display("FAIL dout dut%0d t=%0t got %h expected %h", k, $time, act_dout[k], m_dout[k]);
         else n_pass++;
         if (act_dout[k] !== prev_act[k]) begin
            if (chg_seen[k]) begin
               n_total++;
               if (edge_n - last_chg[k] < per[k])
                  $display("FAIL hold_spacing dut%0d t=%0t got %0d edges expected >= %0d",
                           k, $time, edge_n - last_chg[k], per[k]);
               else n_pass++;
            end
            chg_seen[k] = 1'b1;
            last_chg[k] = edge_n;
            prev_act[k] = act_dout[k];
            if (k == 0) chg_q.push_back(act_dout[k]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      din_valid = 1'b1;
      din       = 4'h1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         n_total++;
         if (act_dout[k] !== '0) $display("FAIL reset_dout dut%0d got %h expected 0", k, act_dout[k]);
         else n_pass++;
         n_total++;
         if (act_rdy[k] !== 1'b0) $display("FAIL reset_ready dut%0d got %b expected 0", k, act_rdy[k]);
         else n_pass++;
         n_total++;
         if (act_busy[k] !== 1'b0) $display("FAIL reset_busy dut%0d got %b expected 0", k, act_busy[k]);
         else n_pass++;
      end
      din_valid = 1'b0;
      resetn    = 1'b1;
      model_reset();
      step(1'b0, '0);
   endtask

   task automatic test_single_change();
      int busy_cnt [NDUT];
      step(1'b1, 4'hA);
      for (int k = 0; k < NDUT; k++) begin
         busy_cnt[k] = 0;
         n_total++;
         if (act_dout[k] !== 4'hA) $display("FAIL single_dout dut%0d got %h expected a", k, act_dout[k]);
         else n_pass++;
      end
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < NDUT; k++) if (act_busy[k] === 1'b1) busy_cnt[k]++;
         step(1'b0, '0);
      end
      for (int k = 0; k < NDUT; k++) begin
         n_total++;
         if (busy_cnt[k] != per[k])
            $display("FAIL single_busy_len dut%0d got %0d expected %0d", k, busy_cnt[k], per[k]);
         else n_pass++;
      end
   endtask

   task automatic test_burst();
      chg_q.delete();
      step(1'b1, 4'h1);
      step(1'b1, 4'h2);
      n_total++;
      if (act_rdy[0] !== 1'b0) $display("FAIL burst_backpressure got %b expected 0", act_rdy[0]);
      else n_pass++;
      repeat (21) step(1'b1, 4'h3);
      repeat (6) step(1'b0, '0);
      n_total++;
      if (chg_q.size() != 3 || chg_q[0] !== 4'h1 || chg_q[1] !== 4'h2 || chg_q[2] !== 4'h3)
         $display("FAIL burst_sequence got %0d changes (first %h) expected 1,2,3",
                  chg_q.size(), (chg_q.size() > 0) ? chg_q[0] : 4'h0);
      else n_pass++;
   endtask

   task automatic test_same_value();
      step(1'b1, 4'h5);
      step(1'b1, 4'h5);
      repeat (6) step(1'b0, '0);
      n_total++;
      if (act_busy[0] !== 1'b0 || act_dout[0] !== 4'h5)
         $display("FAIL same_value_idle got busy=%b dout=%h expected busy=0 dout=5", act_busy[0], act_dout[0]);
      else n_pass++;
      step(1'b1, 4'h5);
      for (int k = 0; k < NDUT; k++) begin
         n_total++;
         if (act_busy[k] !== 1'b0) $display("FAIL same_value_nobusy dut%0d got %b expected 0", k, act_busy[k]);
         else n_pass++;
      end
      step(1'b0, '0);
   endtask

   task automatic test_bypass();
      int t6;
      step(1'b1, 4'h6);
      t6 = last_chg[0];
      repeat (3) step(1'b0, '0);
      step(1'b1, 4'h7);
      n_total++;
      if (act_dout[0] !== 4'h7 || last_chg[0] - t6 != 4)
         $display("FAIL bypass got dout=%h spacing=%0d expected dout=7 spacing=4", act_dout[0], last_chg[0] - t6);
      else n_pass++;
      repeat (6) step(1'b0, '0);
   endtask

   task automatic test_p1_stream();
      logic [W-1:0] v;
      for (int i = 1; i < 16; i++) begin
         v = W'(i);
         step(1'b1, v);
         n_total++;
         if (act_dout[1] !== v) $display("FAIL p1_stream got %h expected %h", act_dout[1], v);
         else n_pass++;
      end
      repeat (4) step(1'b0, '0);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 4'h9);
      step(1'b1, 4'hA);
      step(1'b0, '0);
      #2;
      resetn = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         n_total++;
         if (act_dout[k] !== '0 || act_busy[k] !== 1'b0 || act_rdy[k] !== 1'b0)
            $display("FAIL async_reset dut%0d got dout=%h busy=%b ready=%b expected 0/0/0",
                     k, act_dout[k], act_busy[k], act_rdy[k]);
         else n_pass++;
      end
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      repeat (6) step(1'b0, '0);
      n_total++;
      if (act_dout[0] !== '0) $display("FAIL pending_discarded got %h expected 0", act_dout[0]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [W-1:0] d;
      bit           v;
      for (int i = 0; i < 300; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = W'($urandom_range(0, 3));
         step(v, d);
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_change();
      test_burst();
      test_same_value();
      test_bypass();
      test_p1_stream();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/output_hold_driver.md
# output_hold_driver

Output-side counterpart to input debouncing: drives a DATA_WIDTH-bit output vector (LEDs, external strobes, relay/enable lines) so that every change on `dout` stays stable for at least HOLD_PERIOD clock cycles, regardless of how fast the producer updates. The producer writes new values over a valid/ready handshake. A one-entry pending register absorbs one update during a hold window. The block sits between fabric control logic and the top-level output pins.

## Interface
- DATA_WIDTH, 1: width of `din`/`dout`.
- HOLD_PERIOD, 256: minimum number of cycles `dout` holds a value after a change; legal range is 1 or more.
- HOLD_PERIOD_CLOG2, 8: hold counter width; must represent HOLD_PERIOD-1.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  requested output value.
- din_valid  in  1  `din` is valid this cycle.
- din_ready  out  1  block accepts `din` this cycle; a transfer is din_valid & din_ready at a rising edge.
- dout  out  DATA_WIDTH  registered, hold-guaranteed output.
- busy  out  1  hold window active (state HOLD).

## Operation
- Reset (resetn low, asynchronous): dout=0, pending empty, counter=0, state IDLE. While resetn is low, din_ready=0 and busy=0.
- State IDLE:
  - din_ready=1.
  - Transfer with din != dout: dout<=din, counter<=0, go to HOLD.
  - Transfer with din == dout: value is consumed with no change and no hold; stay in IDLE.
- State HOLD:
  - din_ready = !pending_valid.
  - A transfer before the terminal count stores `din` in the pending register. pending_valid<=1.
  - Counter increments each cycle until it reaches HOLD_PERIOD-1 (terminal count).
- At the terminal-count edge, the next value is chosen in this order:
  - If pending is valid, it is the next value and pending is cleared. din_ready was 0, so there is no input this cycle.
  - Else if a transfer occurs at this same edge (din_ready=1), `din` is the next value directly (bypass).
  - Else there is no next value.
- Action on the next value at terminal count:
  - Next value != dout: dout<=next, counter<=0, stay in HOLD.
  - Next value == dout, or no next value: go to IDLE, counter<=0.
- Only the most recent accepted value matters. The producer sees backpressure and cannot overwrite a full pending register.
- HOLD_PERIOD=1: terminal count is 0, so HOLD lasts exactly one cycle per change. Back-to-back changes are then accepted every cycle through pending or bypass.
- No arithmetic beyond the counter increment. The counter never exceeds HOLD_PERIOD-1, so there is no wrap.

## Timing
- `dout` changes at the rising edge where a transfer (IDLE) or terminal-count load (HOLD) occurs, giving 1-cycle latency from the accepting edge.
- Between any two changes of `dout` there are at least HOLD_PERIOD rising edges; exactly HOLD_PERIOD when an update is pending.
- din_ready and busy are combinational from state and pending_valid only; there is no combinational path from din_valid to din_ready.
- Reset deassertion takes effect at the first rising edge; din_ready=1 in the first cycle after resetn rises.
- Reset asserted mid-hold: dout goes to 0 immediately (asynchronously), and the pending value is discarded.

## Structure
- Shared package holds the state encoding constants (IDLE, HOLD) and a clog2 helper for the default HOLD_PERIOD_CLOG2 check.
- One natural sub-module, `hold_timer`: a counter with start and terminal outputs parameterised by period. The control FSM and the pending register stay in `output_hold_driver`.
- Elaboration-time check that HOLD_PERIOD is at least 1 and that HOLD_PERIOD-1 fits in HOLD_PERIOD_CLOG2 bits.

## Test plan
- Reset: resetn low with din_valid=1 and din=1 -> dout=0, din_ready=0, busy=0. After release, din_ready=1 on the first cycle.
- Single change, DATA_WIDTH=4, HOLD_PERIOD=4: transfer of 4'hA in IDLE -> dout=A the next cycle, busy high for exactly 4 cycles, then IDLE.
- Burst during hold, HOLD_PERIOD=8: send 1, 2, 3 on consecutive cycles -> 1 is loaded, 2 goes to pending, din_ready=0 holds 3 off. dout=1 for 8 cycles, then 2 for 8 cycles. 3 is accepted when din_ready rises and appears after the second window.
- Same-value write: dout=5, pending write of 5 -> at terminal count dout stays 5 and the FSM returns to IDLE with no extra hold. A write of 5 in IDLE causes no busy assertion.
- Bypass at terminal count, HOLD_PERIOD=4: pending empty, transfer of a new value on the terminal-count edge -> dout changes at that edge, counter restarts, and the change spacing is exactly 4 cycles.
- Reset mid-operation and HOLD_PERIOD=1: assert resetn low during HOLD with pending full -> dout=0 asynchronously and pending is discarded. With HOLD_PERIOD=1 and a new value every cycle, dout changes every cycle with no lost values.
